// File: rtl/led_sched_pkg.sv
// Shared types, defaults and round-robin helpers for the LED run scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  localparam int DEF_CNT_W    = 9;
  localparam int DEF_TICK_DIV = 1500000;
  localparam int MAX_REQ      = 8;

  // One-hot winner: first active request after last_grant, wrapping modulo n.
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int unsigned n);
    logic [7:0] win;
    logic [2:0] idx;
    win = 8'd0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = 3'((32'(last) + i) % n);
      if ((i <= n) && (win == 8'd0) && req[idx]) begin
        win[idx] = 1'b1;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_run_scheduler_tick_prescaler.sv
// Free-running divider producing a registered one-clock tick every TICK_DIV clocks.
module tick_prescaler
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_div_cnt;
  logic [W-1:0] w_div_nxt;
  logic         r_tick;

  always_comb begin
    if (r_div_cnt == LAST) begin
      w_div_nxt = {W{1'b0}};
    end else begin
      w_div_nxt = r_div_cnt + W'(1);
    end
  end

  // Tick is registered against the next count so it lines up with div_cnt == TICK_DIV-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= {W{1'b0}};
      r_tick    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_tick    <= (w_div_nxt == LAST);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/led_run_scheduler.sv
// Shares one tick-enabled LED up-counter between NUM_REQ requesters in round-robin order.
module led_run_scheduler
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [CNT_W-1:0]   i_cfg_limit,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_led,
  output logic [NUM_REQ-1:0] o_done,
  output logic               o_tick
);

  state_e             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic [CNT_W-1:0]   r_led;
  logic [CNT_W-1:0]   r_limit;
  logic [2:0]         r_owner;
  logic [2:0]         r_last;
  logic [7:0]         w_win8;
  logic [2:0]         w_win_idx;
  logic               w_tick;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  assign w_win8    = rr_pick(8'(i_req), r_last, NUM_REQ);
  assign w_win_idx = onehot_idx(w_win8);

  // Arbitration and run FSM; owner loss wins over tick, compare precedes increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_grant <= {NUM_REQ{1'b0}};
      r_done  <= {NUM_REQ{1'b0}};
      r_busy  <= 1'b0;
      r_led   <= {CNT_W{1'b0}};
      r_limit <= {CNT_W{1'b0}};
      r_owner <= 3'd0;
      r_last  <= 3'(NUM_REQ - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_req) begin
            r_grant <= NUM_REQ'(w_win8);
            r_owner <= w_win_idx;
            r_limit <= i_cfg_limit;
            r_led   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if ((i_req & r_grant) == {NUM_REQ{1'b0}}) begin
            r_state <= ST_ABORT;
          end else if (w_tick) begin
            if (r_led == r_limit) begin
              r_done  <= r_grant;
              r_state <= ST_DONE;
            end else begin
              r_led <= r_led + CNT_W'(1);
            end
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE, ST_ABORT: begin
          r_done  <= {NUM_REQ{1'b0}};
          r_last  <= r_owner;
          r_grant <= {NUM_REQ{1'b0}};
          r_led   <= {CNT_W{1'b0}};
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= {NUM_REQ{1'b0}};
          r_grant <= {NUM_REQ{1'b0}};
          r_led   <= {CNT_W{1'b0}};
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant = r_grant;
  assign o_busy  = r_busy;
  assign o_led   = r_led;
  assign o_done  = r_done;
  assign o_tick  = w_tick;

endmodule

// File: tb/tb_led_run_scheduler.sv
// Random plus directed bench: two schedulers (TICK_DIV 1 and 4) against a cycle reference model.
module tb_led_run_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [8:0] lim = 9'd0;

  logic [1:0] d_grant [2];
  logic [1:0] d_done  [2];
  logic       d_busy  [2];
  logic       d_tick  [2];
  logic [8:0] d_led   [2];

  led_run_scheduler #(.NUM_REQ(2), .CNT_W(9), .TICK_DIV(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_cfg_limit(lim),
    .o_grant(d_grant[0]), .o_busy(d_busy[0]), .o_led(d_led[0]),
    .o_done(d_done[0]), .o_tick(d_tick[0])
  );

  led_run_scheduler #(.NUM_REQ(2), .CNT_W(9), .TICK_DIV(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_cfg_limit(lim),
    .o_grant(d_grant[1]), .o_busy(d_busy[1]), .o_led(d_led[1]),
    .o_done(d_done[1]), .o_tick(d_tick[1])
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner (-1 = none), phase 0 idle / 1 counting / 2 finished / 3 dropped.
  int m_owner [2];
  int m_led   [2];
  int m_lim   [2];
  int m_phase [2];
  int m_last  [2];
  int m_cyc   [2];
  bit m_tick  [2];

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int pick(input int last, input logic [1:0] r);
    for (int i = 1; i <= 2; i++) begin
      if (r[(last + i) % 2]) return (last + i) % 2;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_led[k] = 0; m_lim[k] = 0; m_phase[k] = 0;
      m_last[k] = 1; m_cyc[k] = 0; m_tick[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      case (m_phase[k])
        0: if (req != 2'b00) begin
             m_owner[k] = pick(m_last[k], req);
             m_lim[k] = int'(lim); m_led[k] = 0; m_phase[k] = 1;
           end
        1: if (!req[m_owner[k]]) m_phase[k] = 3;
           else if (m_tick[k]) begin
             if (m_led[k] == m_lim[k]) m_phase[k] = 2;
             else m_led[k] = m_led[k] + 1;
           end
        default: begin
          m_last[k] = m_owner[k]; m_owner[k] = -1; m_led[k] = 0; m_phase[k] = 0;
        end
      endcase
      m_cyc[k]++;
      m_tick[k] = ((m_cyc[k] % div_of(k)) == div_of(k) - 1);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int eg, ed;
      eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
      ed = (m_phase[k] == 2) ? eg : 0;
      check_val($sformatf("grant%0d", k), 32'(d_grant[k]), 32'(eg));
      check_val($sformatf("busy%0d", k), 32'(d_busy[k]), 32'(m_owner[k] >= 0));
      check_val($sformatf("led%0d", k), 32'(d_led[k]), 32'(m_led[k]));
      check_val($sformatf("done%0d", k), 32'(d_done[k]), 32'(ed));
      check_val($sformatf("tick%0d", k), 32'(d_tick[k]), 32'(m_tick[k]));
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [8:0] l);
    req = r; lim = l;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val("rst_grant", 32'(d_grant[k]), 32'd0);
      check_val("rst_busy", 32'(d_busy[k]), 32'd0);
      check_val("rst_led", 32'(d_led[k]), 32'd0);
      check_val("rst_done", 32'(d_done[k]), 32'd0);
      check_val("rst_tick", 32'(d_tick[k]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bound, o, seen_done, max_led0, max_led1;
    logic [1:0] rr;
    model_reset();
    do_reset();

    // Single requester, limit 3.
    for (int i = 0; i < 30; i++) step(2'b01, 9'd3);
    step(2'b00, 9'd3);
    step(2'b00, 9'd3);

    // Both requesting, limit 1: grants alternate.
    for (int i = 0; i < 60; i++) step(2'b11, 9'd1);
    for (int i = 0; i < 40; i++) step(2'b00, 9'd0);

    // Owner drops at led 5 on the TICK_DIV=1 engine.
    do_reset();
    bound = 0;
    do begin step(2'b11, 9'd20); bound++; end
    while (!(m_phase[0] == 1 && m_led[0] == 5) && bound < 100);
    check_val("abort_reach", 32'(bound < 100), 32'd1);
    o = (m_owner[0] >= 0) ? m_owner[0] : 0;
    rr = 2'b11;
    rr[o] = 1'b0;
    step(rr, 9'd20);
    check_val("abort_nodone1", 32'(d_done[0]), 32'd0);
    step(rr, 9'd20);
    check_val("abort_nodone2", 32'(d_done[0]), 32'd0);
    check_val("abort_idle", 32'(d_busy[0]), 32'd0);
    step(rr, 9'd20);
    check_val("abort_next", 32'(d_grant[0]), 32'(1 << (1 - o)));

    // Full-scale limit: counts to 1FF without wrapping.
    do_reset();
    seen_done = 0; max_led0 = 0; max_led1 = 0;
    bound = 0;
    do begin
      step(2'b01, 9'h1FF);
      if (int'(d_led[0]) > max_led0) max_led0 = int'(d_led[0]);
      if (int'(d_led[1]) > max_led1) max_led1 = int'(d_led[1]);
      if (d_done[1] != 2'b00) seen_done = 1;
      bound++;
    end while (seen_done == 0 && bound < 3000);
    check_val("full_done", 32'(seen_done), 32'd1);
    check_val("full_max0", 32'(max_led0), 32'h1FF);
    check_val("full_max1", 32'(max_led1), 32'h1FF);

    // Reset in the middle of a run at led 7.
    do_reset();
    bound = 0;
    do begin step(2'b01, 9'd20); bound++; end
    while (m_led[0] != 7 && bound < 100);
    check_val("mid_led7", 32'(d_led[0]), 32'd7);
    #2;
    do_reset();
    step(2'b11, 9'd5);
    check_val("rr_first", 32'(d_grant[0]), 32'd1);
    check_val("rr_first1", 32'(d_grant[1]), 32'd1);

    // Randomized traffic.
    rr = 2'b00;
    for (int i = 0; i < 2500; i++) begin
      logic [8:0] l;
      if ($urandom_range(0, 7) == 0) rr = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 5) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end
      step(rr, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
